hbm_write_scheduler: RTL

//  Round-robin scheduler sharing one hbm_auto_write engine among NUM_REQ requesters.
//  - Accepts one write-job descriptor per requester: ops, stride, addr, burst size.
//  - Programs the engine's config inputs, then pulses start_write.
//  - Tracks completion by snooping the engine's AXI W and B channels.
//  - Returns a done token carrying the requester ID and an error flag.

---
 rtl/hbm_write_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hbm_write_scheduler.sv
// Round-robin scheduler that shares one hbm_auto_write engine among NUM_REQ requesters.
// It programs the engine config, pulses start, and counts W/B snoops until the job is done.
module hbm_write_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 33,
    parameter int REQ_IDW    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*32-1:0]         req_ops,
    input  logic [NUM_REQ*32-1:0]         req_stride,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*16-1:0]         req_burst,
    output logic                          eng_start,
    output logic [31:0]                   eng_ops,
    output logic [31:0]                   eng_stride,
    output logic [ADDR_WIDTH-1:0]         eng_addr,
    output logic [15:0]                   eng_burst,
    input  logic                          mon_wvalid,
    input  logic                          mon_wready,
    input  logic                          mon_wlast,
    input  logic                          mon_bvalid,
    input  logic                          mon_bready,
    input  logic [1:0]                    mon_bresp,
    output logic                          done_valid,
    output logic [REQ_IDW-1:0]            done_id,
    output logic                          done_err,
    output logic                          busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LAUNCH,
        RUN,
        DONE
    } state_t;

    localparam logic [REQ_IDW:0]   NUM_REQ_W = NUM_REQ[REQ_IDW:0];
    localparam logic [REQ_IDW-1:0] LAST_IDX  = REQ_IDW'(NUM_REQ - 1);
    // The engine moves 32 bytes per beat, so shorter bursts cannot be issued.
    localparam logic [15:0]        MIN_BURST = 16'd32;

    state_t                  state_reg;
    logic [REQ_IDW-1:0]      rr_ptr_reg;
    logic [REQ_IDW-1:0]      owner_reg;
    logic                    setup_cnt_reg;
    logic                    job_err_reg;
    logic [31:0]             last_cnt_reg;
    logic [31:0]             b_cnt_reg;

    logic [31:0]             ops_arr    [NUM_REQ];
    logic [31:0]             stride_arr [NUM_REQ];
    logic [ADDR_WIDTH-1:0]   addr_arr   [NUM_REQ];
    logic [15:0]             burst_arr  [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign ops_arr[gi]    = req_ops[gi*32 +: 32];
            assign stride_arr[gi] = req_stride[gi*32 +: 32];
            assign addr_arr[gi]   = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign burst_arr[gi]  = req_burst[gi*16 +: 16];
        end
    endgenerate

    logic [REQ_IDW-1:0] grant_idx;
    logic               grant_found;
    logic [REQ_IDW:0]   cand;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_reg} + k[REQ_IDW:0];
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!grant_found && req_valid[cand[REQ_IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[REQ_IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state_reg == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    logic        w_evt;
    logic        b_evt;
    logic [31:0] last_next;
    logic [31:0] b_next;
    logic        err_next;
    logic        burst_illegal;

    assign w_evt         = mon_wvalid & mon_wready & mon_wlast;
    assign b_evt         = mon_bvalid & mon_bready;
    assign last_next     = last_cnt_reg + {31'd0, w_evt};
    assign b_next        = b_cnt_reg + {31'd0, b_evt};
    assign err_next      = job_err_reg | (b_evt && mon_bresp != 2'b00);
    assign burst_illegal = eng_burst < MIN_BURST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            setup_cnt_reg <= 1'b0;
            job_err_reg   <= 1'b0;
            last_cnt_reg  <= '0;
            b_cnt_reg     <= '0;
            eng_start     <= 1'b0;
            eng_ops       <= '0;
            eng_stride    <= '0;
            eng_addr      <= '0;
            eng_burst     <= '0;
            done_valid    <= 1'b0;
            done_id       <= '0;
            done_err      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            eng_start  <= 1'b0;
            done_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        eng_ops       <= ops_arr[grant_idx];
                        eng_stride    <= stride_arr[grant_idx];
                        eng_addr      <= addr_arr[grant_idx];
                        eng_burst     <= burst_arr[grant_idx];
                        owner_reg     <= grant_idx;
                        rr_ptr_reg    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                        setup_cnt_reg <= 1'b0;
                        job_err_reg   <= 1'b0;
                        busy          <= 1'b1;
                        state_reg     <= SETUP;
                    end
                end
                SETUP: begin
                    if (!setup_cnt_reg) begin
                        setup_cnt_reg <= 1'b1;
                    end else if (eng_ops == 32'd0 || burst_illegal) begin
                        done_valid <= 1'b1;
                        done_id    <= owner_reg;
                        done_err   <= burst_illegal;
                        state_reg  <= DONE;
                    end else begin
                        eng_start <= 1'b1;
                        state_reg <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    last_cnt_reg <= '0;
                    b_cnt_reg    <= '0;
                    job_err_reg  <= 1'b0;
                    state_reg    <= RUN;
                end
                RUN: begin
                    // Compare against the post-increment counts so a final event finishes this cycle.
                    last_cnt_reg <= last_next;
                    b_cnt_reg    <= b_next;
                    job_err_reg  <= err_next;
                    if (last_next == eng_ops && b_next == eng_ops) begin
                        done_valid <= 1'b1;
                        done_id    <= owner_reg;
                        done_err   <= err_next;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    done_id   <= '0;
                    done_err  <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
